computational_unit_mc: RTL and testbench
========================================

// Module: computational_unit_mc
// PURPOSE
//  Parametrised, multi-cycle successor of the 4-bit computational unit of the microsequencer CPU.
//  - Holds the x0/x1/y0/y1/r/m/i/o_reg register file, the source-select data bus and the ALU.
//  - Width is set by DATA_W.
//  - Adds carry/negative flags and a sequential shift-add multiplier with a busy output.
//  - The sequencer uses busy to stall.
// PARAMETERS
//  DATA_W      4    width of data bus, every register, i_pins and dm
//  MUL_LAT_W   $clog2(DATA_W+1)  width of multiplier iteration counter (derived, not overridden)
// PORTS
//  clk         in   1         single system clock, rising edge
//  sync_reset  in   1         synchronous, active-high reset
//  i_pins      in   DATA_W    external input pins (source 9)
//  dm          in   DATA_W    data-memory read data (source 7)
//  ir_nibble   in   4         [2:0] ALU function, [3] variant bit; zero-extended to DATA_W as pm_data (source 8)
//  source_sel  in   4         data_bus source select
//  reg_en      in   9         write enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 r/flags, 5 m, 6 i, 7 unused, 8 o_reg
//  i_sel       in   1         0: i<=data_bus, 1: i<=i+m (mod 2^DATA_W)
//  x_sel       in   1         ALU x operand: 0 x0, 1 x1
//  y_sel       in   1         ALU y operand: 0 y0, 1 y1
//  data_bus    out  DATA_W    combinational source mux output
//  x0,x1,y0,y1,r,m,i,o_reg  out  DATA_W each  register contents
//  from_CU     out  2*DATA_W  {x1,x0}
//  r_eq_0      out  1         registered: last ALU result == 0
//  r_carry     out  1         registered: carry (add) / borrow (sub)
//  r_neg       out  1         registered: MSB of last ALU result
//  busy        out  1         registered: multiply in progress
// BEHAVIOUR
//  - Reset
//    - All DATA_W registers go to 0; r_eq_0=1; r_carry=0; r_neg=0; busy=0.
//    - Reset aborts any multiply in progress; r keeps its reset value 0.
//  - data_bus sources
//    - 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 pm_data, 9 i_pins, 10-15 all-zero.
//  - Register writes
//    - All writes happen on the clk edge when their reg_en bit is 1; otherwise the register holds.
//    - Register writes are independent of busy.
//  - Single-cycle ALU ops (reg_en[4]=1, busy=0): r, r_eq_0, r_carry and r_neg update on the same edge.
//    - func 000: v=0 -> -x;   v=1 -> r (hold)
//    - func 001: x-y;         r_carry = borrow (x<y, unsigned)
//    - func 010: x+y;         r_carry = carry-out of the DATA_W+1-bit sum
//    - func 101: x^y
//    - func 110: x&y
//    - func 111: v=0 -> ~x;   v=1 -> r (hold)
//    - r_carry = 0 for every non-add/sub op.
//  - Multiply, func 011 (high half) / 100 (low half), with reg_en[4]=1 and busy=0 at edge N
//    - At edge N: x, y and the half-select are latched and busy goes to 1. r and the flags are unchanged.
//    - Unsigned radix-2 shift-add, one iteration per cycle, into a 2*DATA_W product.
//    - busy is high for exactly DATA_W cycles.
//    - At edge N+DATA_W: r gets the selected half, r_eq_0 and r_neg are updated, r_carry=0, and busy goes to 0.
//    - A new op may start at edge N+DATA_W+1 at the earliest.
//  - While busy=1
//    - reg_en[4] is ignored: no ALU op starts and r/flags are not written by it.
//    - Changing x0..y1 does not affect the result, because operands are latched.
//    - data_bus source 4 returns the old r.
//  - Simultaneous events
//    - sync_reset overrides everything.
//    - Writing r via reg_en[4] and reading r on data_bus in the same cycle returns the old r.
//  - Arithmetic
//    - All single-cycle results are truncated to DATA_W bits.
//    - i+m wraps modulo 2^DATA_W.
// STRUCTURE
//  - Shared package cu_pkg holds:
//    - ALU function codes (ALU_NEG..ALU_NOT)
//    - source_sel codes (SRC_X0..SRC_PINS)
//    - reg_en bit index constants (EN_X0..EN_OREG)
//  - One sub-module, cu_seq_multiplier (params DATA_W):
//    - inputs: clk, sync_reset, start, a, b
//    - outputs: busy, done (1-cycle pulse), product[2*DATA_W-1:0]
//  - The top level holds the register file, the muxes, the single-cycle ALU and the flag logic.
// TESTING
//  1. Reset, DATA_W=4: assert sync_reset one cycle -> all regs 0, r_eq_0=1, busy=0, data_bus(src 10)=0.
//  2. Add carry, DATA_W=4: x0=4'hC, y0=4'h7, func 010, reg_en[4] -> r=4'h3, r_carry=1, r_eq_0=0, r_neg=0.
//  3. Sub borrow, DATA_W=8: x0=8'h05, y0=8'h06, func 001 -> r=8'hFF, r_carry=1, r_neg=1.
//  4. Multiply, DATA_W=4: x1=4'hF, y1=4'hF, func 011 (high half)
//     -> busy high exactly 4 cycles; r=4'hE at the busy-falling edge.
//     Repeating with func 100 (low half) -> r=4'h1.
//     reg_en[4] pulses during busy are ignored, and overwriting x1 mid-multiply has no effect on the result.
//  5. Reset mid-multiply, DATA_W=8: start 8'h10*8'h10, assert sync_reset on cycle 3 -> busy=0 next edge, r=0, r_eq_0=1.
//  6. Index/source: m=4'h3, i=4'hE, i_sel=1, reg_en[6] -> i=4'h1 (wrap).
//     source_sel=8 with ir_nibble=4'hA -> data_bus=4'hA.
//     reg_en[8] -> o_reg=4'hA.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle computational unit: ALU function codes,
// data-bus source codes, register-enable bit positions and the multiplier state type.
package cu_pkg;

    localparam logic [2:0] ALU_NEG  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_MULH = 3'b011;
    localparam logic [2:0] ALU_MULL = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_NOT  = 3'b111;

    localparam logic [3:0] SRC_X0   = 4'd0;
    localparam logic [3:0] SRC_X1   = 4'd1;
    localparam logic [3:0] SRC_Y0   = 4'd2;
    localparam logic [3:0] SRC_Y1   = 4'd3;
    localparam logic [3:0] SRC_R    = 4'd4;
    localparam logic [3:0] SRC_M    = 4'd5;
    localparam logic [3:0] SRC_I    = 4'd6;
    localparam logic [3:0] SRC_DM   = 4'd7;
    localparam logic [3:0] SRC_PM   = 4'd8;
    localparam logic [3:0] SRC_PINS = 4'd9;

    localparam int EN_X0   = 0;
    localparam int EN_X1   = 1;
    localparam int EN_Y0   = 2;
    localparam int EN_Y1   = 3;
    localparam int EN_R    = 4;
    localparam int EN_M    = 5;
    localparam int EN_I    = 6;
    localparam int EN_OREG = 8;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

    function automatic logic is_mul(input logic [2:0] func);
        return (func == ALU_MULH) || (func == ALU_MULL);
    endfunction

endpackage

// File: rtl/cu_seq_multiplier.sv
// Unsigned radix-2 shift-add multiplier. The first partial product is folded into the
// start edge so busy spans exactly DATA_W cycles and done marks the final busy cycle.
module cu_seq_multiplier
    import cu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int MUL_LAT_W = $clog2(DATA_W + 1);
    localparam logic [MUL_LAT_W-1:0] LAST_ITER = MUL_LAT_W'(DATA_W);

    mul_state_e               state_q, state_d;
    logic [DATA_W-1:0]        a_q, a_d;
    logic [2*DATA_W-1:0]      prod_q, prod_d;
    logic [MUL_LAT_W-1:0]     cnt_q, cnt_d;
    logic                     done_q, done_d;
    logic [DATA_W:0]          first_sum_s;
    logic [DATA_W:0]          step_sum_s;

    // Lower half of prod_q holds the not-yet-consumed multiplier bits.
    assign first_sum_s = {1'b0, (b[0] ? a : {DATA_W{1'b0}})};
    assign step_sum_s  = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                       + {1'b0, (prod_q[0] ? a_q : {DATA_W{1'b0}})};

    // Next-state and datapath iteration
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d = MUL_RUN;
                    a_d     = a;
                    prod_d  = (2*DATA_W)'({first_sum_s, b} >> 1);
                    cnt_d   = MUL_LAT_W'(1);
                    done_d  = (cnt_d == LAST_ITER);
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = MUL_IDLE;
                end else begin
                    prod_d = (2*DATA_W)'({step_sum_s, prod_q[DATA_W-1:0]} >> 1);
                    cnt_d  = cnt_q + MUL_LAT_W'(1);
                    done_d = (cnt_d == LAST_ITER);
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= MUL_IDLE;
            a_q     <= {DATA_W{1'b0}};
            prod_q  <= {(2*DATA_W){1'b0}};
            cnt_q   <= {MUL_LAT_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == MUL_RUN);
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/computational_unit_mc.sv
// Register file, source-select data bus, single-cycle ALU with flags and the
// hand-off to the sequential multiplier for the microsequencer datapath.
module computational_unit_mc
    import cu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [DATA_W-1:0]     i_pins,
    input  logic [DATA_W-1:0]     dm,
    input  logic [3:0]            ir_nibble,
    input  logic [3:0]            source_sel,
    input  logic [8:0]            reg_en,
    input  logic                  i_sel,
    input  logic                  x_sel,
    input  logic                  y_sel,
    output logic [DATA_W-1:0]     data_bus,
    output logic [DATA_W-1:0]     x0,
    output logic [DATA_W-1:0]     x1,
    output logic [DATA_W-1:0]     y0,
    output logic [DATA_W-1:0]     y1,
    output logic [DATA_W-1:0]     r,
    output logic [DATA_W-1:0]     m,
    output logic [DATA_W-1:0]     i,
    output logic [DATA_W-1:0]     o_reg,
    output logic [2*DATA_W-1:0]   from_CU,
    output logic                  r_eq_0,
    output logic                  r_carry,
    output logic                  r_neg,
    output logic                  busy
);

    logic [DATA_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [DATA_W-1:0] r_q, r_d, m_q, m_d, i_q, i_d, o_q, o_d;
    logic              eq_q, eq_d, carry_q, carry_d, neg_q, neg_d, hi_sel_q, hi_sel_d;
    logic [DATA_W-1:0] data_bus_s, pm_data_s, x_op_s, y_op_s, alu_res_s;
    logic [DATA_W:0]   sum_s, diff_s;
    logic              alu_carry_s, alu_go_s, mul_start_s, mul_busy_s, mul_done_s;
    logic [2:0]        alu_func_s;
    logic              alu_var_s;
    logic [2*DATA_W-1:0] mul_prod_s;

    assign alu_func_s  = ir_nibble[2:0];
    assign alu_var_s   = ir_nibble[3];
    assign pm_data_s   = DATA_W'(ir_nibble);
    assign x_op_s      = x_sel ? x1_q : x0_q;
    assign y_op_s      = y_sel ? y1_q : y0_q;
    assign sum_s       = {1'b0, x_op_s} + {1'b0, y_op_s};
    assign diff_s      = {1'b0, x_op_s} - {1'b0, y_op_s};
    assign alu_go_s    = reg_en[EN_R] & ~mul_busy_s & ~is_mul(alu_func_s);
    assign mul_start_s = reg_en[EN_R] & ~mul_busy_s &  is_mul(alu_func_s);

    // Data bus source select
    always_comb begin
        data_bus_s = {DATA_W{1'b0}};
        case (source_sel)
            SRC_X0:   data_bus_s = x0_q;
            SRC_X1:   data_bus_s = x1_q;
            SRC_Y0:   data_bus_s = y0_q;
            SRC_Y1:   data_bus_s = y1_q;
            SRC_R:    data_bus_s = r_q;
            SRC_M:    data_bus_s = m_q;
            SRC_I:    data_bus_s = i_q;
            SRC_DM:   data_bus_s = dm;
            SRC_PM:   data_bus_s = pm_data_s;
            SRC_PINS: data_bus_s = i_pins;
            default:  data_bus_s = {DATA_W{1'b0}};
        endcase
    end

    // Single-cycle ALU; multiply codes fall through to hold r
    always_comb begin
        alu_res_s   = r_q;
        alu_carry_s = 1'b0;
        case (alu_func_s)
            ALU_NEG: alu_res_s = alu_var_s ? r_q : ({DATA_W{1'b0}} - x_op_s);
            ALU_SUB: begin
                alu_res_s   = diff_s[DATA_W-1:0];
                alu_carry_s = diff_s[DATA_W];
            end
            ALU_ADD: begin
                alu_res_s   = sum_s[DATA_W-1:0];
                alu_carry_s = sum_s[DATA_W];
            end
            ALU_XOR: alu_res_s = x_op_s ^ y_op_s;
            ALU_AND: alu_res_s = x_op_s & y_op_s;
            ALU_NOT: alu_res_s = alu_var_s ? r_q : ~x_op_s;
            default: alu_res_s = r_q;
        endcase
    end

    // Register file next-state, including r/flag updates from ALU or multiplier
    always_comb begin
        x0_d = reg_en[EN_X0] ? data_bus_s : x0_q;
        x1_d = reg_en[EN_X1] ? data_bus_s : x1_q;
        y0_d = reg_en[EN_Y0] ? data_bus_s : y0_q;
        y1_d = reg_en[EN_Y1] ? data_bus_s : y1_q;
        m_d  = reg_en[EN_M]  ? data_bus_s : m_q;
        o_d  = reg_en[EN_OREG] ? data_bus_s : o_q;
        if (reg_en[EN_I]) begin
            i_d = i_sel ? (i_q + m_q) : data_bus_s;
        end else begin
            i_d = i_q;
        end
        hi_sel_d = mul_start_s ? (alu_func_s == ALU_MULH) : hi_sel_q;
        r_d     = r_q;
        eq_d    = eq_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        if (mul_done_s) begin
            r_d     = hi_sel_q ? mul_prod_s[2*DATA_W-1:DATA_W] : mul_prod_s[DATA_W-1:0];
            eq_d    = (r_d == {DATA_W{1'b0}});
            carry_d = 1'b0;
            neg_d   = r_d[DATA_W-1];
        end else if (alu_go_s) begin
            r_d     = alu_res_s;
            eq_d    = (alu_res_s == {DATA_W{1'b0}});
            carry_d = alu_carry_s;
            neg_d   = alu_res_s[DATA_W-1];
        end else begin
            r_d = r_q;
        end
    end

    // Register file and flag flops
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            x0_q <= {DATA_W{1'b0}};  x1_q <= {DATA_W{1'b0}};
            y0_q <= {DATA_W{1'b0}};  y1_q <= {DATA_W{1'b0}};
            r_q  <= {DATA_W{1'b0}};  m_q  <= {DATA_W{1'b0}};
            i_q  <= {DATA_W{1'b0}};  o_q  <= {DATA_W{1'b0}};
            eq_q <= 1'b1;  carry_q <= 1'b0;  neg_q <= 1'b0;  hi_sel_q <= 1'b0;
        end else begin
            x0_q <= x0_d;  x1_q <= x1_d;  y0_q <= y0_d;  y1_q <= y1_d;
            r_q  <= r_d;   m_q  <= m_d;   i_q  <= i_d;   o_q  <= o_d;
            eq_q <= eq_d;  carry_q <= carry_d;  neg_q <= neg_d;  hi_sel_q <= hi_sel_d;
        end
    end

    cu_seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk        (clk),
        .sync_reset (sync_reset),
        .start      (mul_start_s),
        .a          (x_op_s),
        .b          (y_op_s),
        .busy       (mul_busy_s),
        .done       (mul_done_s),
        .product    (mul_prod_s)
    );

    assign data_bus = data_bus_s;
    assign x0 = x0_q;  assign x1 = x1_q;  assign y0 = y0_q;  assign y1 = y1_q;
    assign r  = r_q;   assign m  = m_q;   assign i  = i_q;   assign o_reg = o_q;
    assign from_CU = {x1_q, x0_q};
    assign r_eq_0  = eq_q;
    assign r_carry = carry_q;
    assign r_neg   = neg_q;
    assign busy    = mul_busy_s;

endmodule

// File: tb/tb_computational_unit_mc.sv
// Directed bench for computational_unit_mc with one 4-bit and one 8-bit instance.
module tb_computational_unit_mc;
    import cu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        sr4, isel4, xsel4, ysel4;
    logic [3:0]  pins4, dm4, ir4, src4;
    logic [8:0]  en4;
    logic [3:0]  bus4, x0_4, x1_4, y0_4, y1_4, r4, m4, i4, o4;
    logic [7:0]  fcu4;
    logic        eq4, cy4, ng4, busy4;

    logic        sr8, isel8, xsel8, ysel8;
    logic [7:0]  pins8, dm8;
    logic [3:0]  ir8, src8;
    logic [8:0]  en8;
    logic [7:0]  bus8, x0_8, x1_8, y0_8, y1_8, r8, m8, i8, o8;
    logic [15:0] fcu8;
    logic        eq8, cy8, ng8, busy8;

    computational_unit_mc #(.DATA_W(4)) u_dut4 (
        .clk(clk), .sync_reset(sr4), .i_pins(pins4), .dm(dm4), .ir_nibble(ir4),
        .source_sel(src4), .reg_en(en4), .i_sel(isel4), .x_sel(xsel4), .y_sel(ysel4),
        .data_bus(bus4), .x0(x0_4), .x1(x1_4), .y0(y0_4), .y1(y1_4), .r(r4), .m(m4),
        .i(i4), .o_reg(o4), .from_CU(fcu4), .r_eq_0(eq4), .r_carry(cy4), .r_neg(ng4),
        .busy(busy4)
    );

    computational_unit_mc #(.DATA_W(8)) u_dut8 (
        .clk(clk), .sync_reset(sr8), .i_pins(pins8), .dm(dm8), .ir_nibble(ir8),
        .source_sel(src8), .reg_en(en8), .i_sel(isel8), .x_sel(xsel8), .y_sel(ysel8),
        .data_bus(bus8), .x0(x0_8), .x1(x1_8), .y0(y0_8), .y1(y1_8), .r(r8), .m(m8),
        .i(i8), .o_reg(o8), .from_CU(fcu8), .r_eq_0(eq8), .r_carry(cy8), .r_neg(ng8),
        .busy(busy8)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load4(input int idx, input logic [3:0] v);
        src4 = SRC_PINS; pins4 = v; en4 = 9'b0; en4[idx] = 1'b1;
        tick();
        en4 = 9'b0;
    endtask

    task automatic load8(input int idx, input logic [7:0] v);
        src8 = SRC_PINS; pins8 = v; en8 = 9'b0; en8[idx] = 1'b1;
        tick();
        en8 = 9'b0;
    endtask

    initial begin
        int cyc;
        sr4 = 1'b1; isel4 = 1'b0; xsel4 = 1'b0; ysel4 = 1'b0;
        pins4 = 4'h0; dm4 = 4'h0; ir4 = 4'h0; src4 = 4'd10; en4 = 9'b0;
        sr8 = 1'b1; isel8 = 1'b0; xsel8 = 1'b0; ysel8 = 1'b0;
        pins8 = 8'h00; dm8 = 8'h00; ir8 = 4'h0; src8 = 4'd10; en8 = 9'b0;
        tick();
        sr4 = 1'b0; sr8 = 1'b0;

        // Reset state
        check_val("rst_x0", x0_4, 32'h0);   check_val("rst_x1", x1_4, 32'h0);
        check_val("rst_y0", y0_4, 32'h0);   check_val("rst_y1", y1_4, 32'h0);
        check_val("rst_r", r4, 32'h0);      check_val("rst_m", m4, 32'h0);
        check_val("rst_i", i4, 32'h0);      check_val("rst_o", o4, 32'h0);
        check_val("rst_eq", eq4, 32'h1);    check_val("rst_cy", cy4, 32'h0);
        check_val("rst_neg", ng4, 32'h0);   check_val("rst_busy", busy4, 32'h0);
        check_val("rst_bus10", bus4, 32'h0);
        src4 = SRC_DM; dm4 = 4'h5; #1;
        check_val("bus_dm", bus4, 32'h5);

        // Add with carry
        load4(EN_X0, 4'hC);
        load4(EN_Y0, 4'h7);
        ir4 = {1'b0, ALU_ADD}; en4[EN_R] = 1'b1;
        tick();
        en4 = 9'b0;
        check_val("add_r", r4, 32'h3);      check_val("add_cy", cy4, 32'h1);
        check_val("add_eq", eq4, 32'h0);    check_val("add_neg", ng4, 32'h0);

        // XOR while reading r on the bus: bus shows old r
        src4 = SRC_R; ir4 = {1'b0, ALU_XOR}; en4[EN_R] = 1'b1; #1;
        check_val("bus_old_r", bus4, 32'h3);
        tick();
        en4 = 9'b0;
        check_val("xor_r", r4, 32'hB);      check_val("xor_cy", cy4, 32'h0);
        check_val("bus_new_r", bus4, 32'hB);

        // Multiply high half, with ignored ALU request and x1 overwrite mid-flight
        load4(EN_X1, 4'hF);
        load4(EN_Y1, 4'hF);
        check_val("from_cu", fcu4, 32'hFC);
        xsel4 = 1'b1; ysel4 = 1'b1; ir4 = {1'b0, ALU_MULH}; en4[EN_R] = 1'b1;
        tick();
        en4 = 9'b0;
        check_val("mulh_busy", busy4, 32'h1);
        check_val("mulh_r_hold", r4, 32'hB);
        cyc = 1;
        for (int k = 0; k < 40 && busy4; k++) begin
            en4 = 9'b0;
            if (k == 0) begin
                ir4 = {1'b0, ALU_ADD}; en4[EN_R] = 1'b1;
            end else if (k == 1) begin
                src4 = SRC_PINS; pins4 = 4'h0; en4[EN_X1] = 1'b1;
            end
            tick();
            if (busy4) cyc++;
        end
        en4 = 9'b0;
        check_val("mulh_cycles", cyc, 32'd4);
        check_val("mulh_r", r4, 32'hE);     check_val("mulh_neg", ng4, 32'h1);
        check_val("mulh_eq", eq4, 32'h0);   check_val("mulh_cy", cy4, 32'h0);
        check_val("mid_x1", x1_4, 32'h0);

        // Multiply low half
        load4(EN_X1, 4'hF);
        ir4 = {1'b0, ALU_MULL}; en4[EN_R] = 1'b1;
        tick();
        en4 = 9'b0;
        cyc = 1;
        for (int k = 0; k < 40 && busy4; k++) begin
            tick();
            if (busy4) cyc++;
        end
        check_val("mull_cycles", cyc, 32'd4);
        check_val("mull_r", r4, 32'h1);     check_val("mull_neg", ng4, 32'h0);

        // Negate, then variant-1 hold
        xsel4 = 1'b0; ir4 = {1'b0, ALU_NEG}; en4[EN_R] = 1'b1;
        tick();
        check_val("neg_r", r4, 32'h4);
        ir4 = 4'b1000;
        tick();
        en4 = 9'b0;
        check_val("hold_r", r4, 32'h4);

        // Index wrap, pm_data source and o_reg
        load4(EN_M, 4'h3);
        load4(EN_I, 4'hE);
        isel4 = 1'b1; en4[EN_I] = 1'b1;
        tick();
        en4 = 9'b0; isel4 = 1'b0;
        check_val("i_wrap", i4, 32'h1);
        src4 = SRC_PM; ir4 = 4'hA; #1;
        check_val("bus_pm", bus4, 32'hA);
        en4[EN_OREG] = 1'b1;
        tick();
        en4 = 9'b0;
        check_val("o_reg", o4, 32'hA);

        // 8-bit subtract with borrow
        load8(EN_X0, 8'h05);
        load8(EN_Y0, 8'h06);
        ir8 = {1'b0, ALU_SUB}; en8[EN_R] = 1'b1;
        tick();
        en8 = 9'b0;
        check_val("sub_r", r8, 32'hFF);     check_val("sub_cy", cy8, 32'h1);
        check_val("sub_neg", ng8, 32'h1);   check_val("sub_eq", eq8, 32'h0);

        // 8-bit multiply aborted by reset
        load8(EN_X0, 8'h10);
        load8(EN_Y0, 8'h10);
        ir8 = {1'b0, ALU_MULH}; en8[EN_R] = 1'b1;
        tick();
        en8 = 9'b0;
        tick();
        tick();
        check_val("mul8_busy", busy8, 32'h1);
        sr8 = 1'b1;
        tick();
        sr8 = 1'b0;
        check_val("abort_busy", busy8, 32'h0);
        check_val("abort_r", r8, 32'h0);
        check_val("abort_eq", eq8, 32'h1);
        for (int k = 0; k < 10; k++) tick();
        check_val("abort_r_late", r8, 32'h0);
        check_val("abort_busy_late", busy8, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
